// File: rtl/mem_arbiter.sv
// mem_arbiter: N-master fixed-priority / round-robin arbiter onto one memory port.
// Optional starvation guard is compiled in with MEM_ARBITER_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int N_MASTERS    = 4,
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int RR_MODE      = 0,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [N_MASTERS*AW-1:0]   m_addr,
  input  logic [N_MASTERS*DW-1:0]   m_wdata,
  input  logic [2*N_MASTERS-1:0]    m_width,
  input  logic [N_MASTERS-1:0]      m_read,
  input  logic [N_MASTERS-1:0]      m_write,
  input  logic [N_MASTERS-1:0]      m_lock,
  output logic [N_MASTERS-1:0]      m_ok,
  output logic [DW-1:0]             m_rdata,
  output logic [AW-1:0]             s_addr,
  output logic [DW-1:0]             s_wdata,
  output logic [1:0]                s_width,
  output logic                      s_read,
  output logic                      s_write,
  input  logic [DW-1:0]             s_rdata,
  input  logic                      s_ok,
  output logic [$clog2(N_MASTERS)-1:0] grant
);

  localparam int GW = $clog2(N_MASTERS);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           rst_sync_q, rst_sync_d;
  logic                 rst_ni;

  logic [AW-1:0]        s_addr_q, s_addr_d;
  logic [DW-1:0]        s_wdata_q, s_wdata_d;
  logic [1:0]           s_width_q, s_width_d;
  logic                 s_read_q, s_read_d;
  logic                 s_write_q, s_write_d;
  logic [DW-1:0]        m_rdata_q, m_rdata_d;
  logic [N_MASTERS-1:0] m_ok_q, m_ok_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 lock_q, lock_d;

  logic [N_MASTERS-1:0] req;
  logic [N_MASTERS-1:0] cand;
  logic [N_MASTERS-1:0] owner_oh;
  logic                 lock_eff;
  logic [GW-1:0]        win;
  logic                 win_vld;
  logic [GW-1:0]        idx;

  // Reset asserts immediately but releases two edges later.
  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_ni = rst_sync_q[1];

  assign req = m_read | m_write;

  always_comb begin
    owner_oh = '0;
    owner_oh[grant_q] = 1'b1;
  end

  assign lock_eff = lock_q & m_lock[grant_q];
  assign cand     = lock_eff ? (req & owner_oh) : req;

`ifdef MEM_ARBITER_STARVE_GUARD_EN
  logic [7:0]           cnt_q [N_MASTERS];
  logic [7:0]           cnt_d [N_MASTERS];
  logic [N_MASTERS-1:0] force_m;

  always_comb begin
    force_m = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      force_m[GW'(i)] = req[GW'(i)] &&
                        (int'(cnt_q[GW'(i)]) >= STARVE_LIMIT);
    end
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
`endif

  // Reverse scans let the first hit in search order win.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    if (RR_MODE == 0) begin
      for (int i = N_MASTERS - 1; i >= 0; i--) begin
        if (cand[GW'(i)]) begin
          win     = GW'(i);
          win_vld = 1'b1;
        end
      end
    end else begin
      for (int k = N_MASTERS; k >= 1; k--) begin
        idx = GW'((int'(rr_ptr_q) + k) % N_MASTERS);
        if (cand[idx]) begin
          win     = idx;
          win_vld = 1'b1;
        end
      end
    end
`ifdef MEM_ARBITER_STARVE_GUARD_EN
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (force_m[GW'(i)]) begin
        win     = GW'(i);
        win_vld = 1'b1;
      end
    end
`endif
  end

`ifdef MEM_ARBITER_STARVE_GUARD_EN
  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      cnt_d[GW'(i)] = cnt_q[GW'(i)];
      if (!req[GW'(i)]) begin
        cnt_d[GW'(i)] = '0;
      end else if (state_q == IDLE && win_vld) begin
        if (win == GW'(i)) begin
          cnt_d[GW'(i)] = '0;
        end else if (cnt_q[GW'(i)] != 8'hFF) begin
          cnt_d[GW'(i)] = cnt_q[GW'(i)] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        cnt_q[GW'(i)] <= '0;
      end
    end else begin
      for (int i = 0; i < N_MASTERS; i++) begin
        cnt_q[GW'(i)] <= cnt_d[GW'(i)];
      end
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_width_d = s_width_q;
    s_read_d  = s_read_q;
    s_write_d = s_write_q;
    m_rdata_d = m_rdata_q;
    m_ok_d    = '0;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    lock_d    = lock_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d   = BUSY;
          grant_d   = win;
          rr_ptr_d  = win;
          lock_d    = 1'b0;
          s_addr_d  = m_addr[int'(win)*AW +: AW];
          s_wdata_d = m_wdata[int'(win)*DW +: DW];
          s_width_d = m_width[int'(win)*2 +: 2];
          s_read_d  = m_read[win];
          s_write_d = m_write[win] & ~m_read[win];
        end
      end
      BUSY: begin
        if (s_ok) begin
          state_d   = DONE;
          s_read_d  = 1'b0;
          s_write_d = 1'b0;
          m_ok_d    = owner_oh;
          if (s_read_q) begin
            m_rdata_d = s_rdata;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        lock_d  = m_lock[grant_q];
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_width_q <= '0;
      s_read_q  <= 1'b0;
      s_write_q <= 1'b0;
      m_rdata_q <= '0;
      m_ok_q    <= '0;
      grant_q   <= '0;
      rr_ptr_q  <= GW'(N_MASTERS - 1);
      lock_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_width_q <= s_width_d;
      s_read_q  <= s_read_d;
      s_write_q <= s_write_d;
      m_rdata_q <= m_rdata_d;
      m_ok_q    <= m_ok_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
    end
  end

  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;
  assign s_width = s_width_q;
  assign s_read  = s_read_q;
  assign s_write = s_write_q;
  assign m_rdata = m_rdata_q;
  assign m_ok    = m_ok_q;
  assign grant   = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter in fixed-priority and round-robin modes.
// Two instances share master inputs; each has its own slave side.
module tb_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [2*N-1:0]  m_width;
  logic [N-1:0]    m_read, m_write, m_lock;

  logic [N-1:0]  m_ok_fp, m_ok_rr;
  logic [DW-1:0] m_rdata_fp, m_rdata_rr;
  logic [AW-1:0] s_addr_fp, s_addr_rr;
  logic [DW-1:0] s_wdata_fp, s_wdata_rr;
  logic [1:0]    s_width_fp, s_width_rr;
  logic          s_read_fp, s_read_rr;
  logic          s_write_fp, s_write_rr;
  logic [DW-1:0] s_rdata_fp, s_rdata_rr;
  logic          s_ok_fp, s_ok_rr;
  logic [1:0]    grant_fp, grant_rr;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(
    .N_MASTERS(N), .AW(AW), .DW(DW), .RR_MODE(0), .STARVE_LIMIT(4)
  ) dut_fp (
    .clk(clk), .rstn(rstn),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_width(m_width),
    .m_read(m_read), .m_write(m_write), .m_lock(m_lock),
    .m_ok(m_ok_fp), .m_rdata(m_rdata_fp),
    .s_addr(s_addr_fp), .s_wdata(s_wdata_fp), .s_width(s_width_fp),
    .s_read(s_read_fp), .s_write(s_write_fp),
    .s_rdata(s_rdata_fp), .s_ok(s_ok_fp), .grant(grant_fp)
  );

  mem_arbiter #(
    .N_MASTERS(N), .AW(AW), .DW(DW), .RR_MODE(1), .STARVE_LIMIT(64)
  ) dut_rr (
    .clk(clk), .rstn(rstn),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_width(m_width),
    .m_read(m_read), .m_write(m_write), .m_lock(m_lock),
    .m_ok(m_ok_rr), .m_rdata(m_rdata_rr),
    .s_addr(s_addr_rr), .s_wdata(s_wdata_rr), .s_width(s_width_rr),
    .s_read(s_read_rr), .s_write(s_write_rr),
    .s_rdata(s_rdata_rr), .s_ok(s_ok_rr), .grant(grant_rr)
  );

  task automatic clear_inputs();
    m_addr     = '0;
    m_wdata    = '0;
    m_width    = '0;
    m_read     = '0;
    m_write    = '0;
    m_lock     = '0;
    s_rdata_fp = '0;
    s_rdata_rr = '0;
    s_ok_fp    = 1'b0;
    s_ok_rr    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    rstn = 1'b1;
    #1 rstn = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({s_read_fp, s_write_fp} !== 2'b00 || s_addr_fp !== '0 ||
        s_wdata_fp !== '0 || s_width_fp !== 2'd0 ||
        m_rdata_fp !== '0 || m_ok_fp !== '0 || grant_fp !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_fp: rd=%b wr=%b addr=%h wd=%h w=%0d rdata=%h ok=%b g=%0d want all zero",
               s_read_fp, s_write_fp, s_addr_fp, s_wdata_fp, s_width_fp,
               m_rdata_fp, m_ok_fp, grant_fp);
    end
    n_tests++;
    if ({s_read_rr, s_write_rr} !== 2'b00 || s_addr_rr !== '0 ||
        s_wdata_rr !== '0 || s_width_rr !== 2'd0 ||
        m_rdata_rr !== '0 || m_ok_rr !== '0 || grant_rr !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_rr: rd=%b wr=%b addr=%h wd=%h w=%0d rdata=%h ok=%b g=%0d want all zero",
               s_read_rr, s_write_rr, s_addr_rr, s_wdata_rr, s_width_rr,
               m_rdata_rr, m_ok_rr, grant_rr);
    end
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    s_ok_fp = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_tests++;
      if (m_ok_fp !== '0 || s_read_fp !== 1'b0) begin
        n_fail++;
        $display("FAIL stray_s_ok: ok=%b rd=%b want 0 0", m_ok_fp, s_read_fp);
      end
    end
    s_ok_fp = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    m_read[2]            = 1'b1;
    m_addr[2*AW +: AW]   = 32'h0300_0010;
    m_width[5:4]         = 2'd2;
    s_rdata_fp           = 32'hDEAD_BEEF;
    @(negedge clk);
    n_tests++;
    if (s_read_fp !== 1'b1 || s_addr_fp !== 32'h0300_0010 ||
        grant_fp !== 2'd2 || s_width_fp !== 2'd2) begin
      n_fail++;
      $display("FAIL single_grant: rd=%b addr=%h g=%0d w=%0d want 1 03000010 2 2",
               s_read_fp, s_addr_fp, grant_fp, s_width_fp);
    end
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (s_read_fp !== 1'b1 || m_ok_fp !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_wait: rd=%b ok=%b want 1 0000", s_read_fp, m_ok_fp);
    end
    s_ok_fp = 1'b1;
    @(negedge clk);
    s_ok_fp = 1'b0;
    n_tests++;
    if (m_ok_fp !== 4'b0100 || m_rdata_fp !== 32'hDEAD_BEEF ||
        s_read_fp !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: ok=%b rdata=%h rd=%b want 0100 deadbeef 0",
               m_ok_fp, m_rdata_fp, s_read_fp);
    end
    m_read[2] = 1'b0;
    @(negedge clk);
    n_tests++;
    if (m_ok_fp !== 4'b0000 || grant_fp !== 2'd2) begin
      n_fail++;
      $display("FAIL single_pulse: ok=%b g=%0d want 0000 2", m_ok_fp, grant_fp);
    end
  endtask

  task automatic test_fixed_priority();
    logic [N-1:0] who [4];
    int           cyc [4];
    int           np;
    np = 0;
    for (int k = 0; k < 4; k++) begin
      who[k] = '0;
      cyc[k] = 0;
    end
    do_reset();
    s_ok_fp    = 1'b1;
    s_rdata_fp = 32'h1234_5678;
    m_read[1]  = 1'b1;
    m_read[3]  = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_tests++;
        if (grant_fp !== 2'd1 || s_read_fp !== 1'b1) begin
          n_fail++;
          $display("FAIL fp_first_grant: g=%0d rd=%b want 1 1", grant_fp, s_read_fp);
        end
      end
      if (m_ok_fp !== '0) begin
        if (np < 4) begin
          who[np] = m_ok_fp;
          cyc[np] = c;
        end
        np++;
        m_read = m_read & ~m_ok_fp;
      end
    end
    n_tests++;
    if (np !== 2 || who[0] !== 4'b0010 || who[1] !== 4'b1000) begin
      n_fail++;
      $display("FAIL fp_order: pulses=%0d first=%b second=%b want 2 0010 1000",
               np, who[0], who[1]);
    end
    n_tests++;
    if (cyc[0] !== 2 || cyc[1] - cyc[0] !== 3) begin
      n_fail++;
      $display("FAIL fp_spacing: first=%0d gap=%0d want 2 3", cyc[0], cyc[1] - cyc[0]);
    end
    m_read = '0;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] who [8];
    int           cyc [8];
    logic [N-1:0] exp_who;
    int           np;
    np = 0;
    for (int k = 0; k < 8; k++) begin
      who[k] = '0;
      cyc[k] = 0;
    end
    do_reset();
    s_ok_rr    = 1'b1;
    s_rdata_rr = 32'h0BAD_F00D;
    m_read     = 4'hF;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (m_ok_rr !== '0) begin
        if (np < 8) begin
          who[np] = m_ok_rr;
          cyc[np] = c;
        end
        np++;
      end
    end
    n_tests++;
    if (np !== 5) begin
      n_fail++;
      $display("FAIL rr_count: pulses=%0d want 5", np);
    end
    for (int k = 0; k < 5; k++) begin
      exp_who = 4'b0001 << (k % 4);
      n_tests++;
      if (who[k] !== exp_who || cyc[k] !== 2 + 3 * k) begin
        n_fail++;
        $display("FAIL rr_pulse%0d: ok=%b at %0d want %b at %0d",
                 k, who[k], cyc[k], exp_who, 2 + 3 * k);
      end
    end
    n_tests++;
    if (cyc[4] - cyc[0] !== 12 || m_rdata_rr !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL rr_period: period=%0d rdata=%h want 12 0badf00d",
               cyc[4] - cyc[0], m_rdata_rr);
    end
    m_read  = '0;
    s_ok_rr = 1'b0;
  endtask

  task automatic test_lock();
    do_reset();
    s_ok_fp            = 1'b1;
    s_rdata_fp         = 32'hCAFE_0001;
    m_write[0]         = 1'b1;
    m_wdata[0 +: DW]   = 32'h11;
    m_lock[0]          = 1'b1;
    m_read[1]          = 1'b1;
    m_addr[AW +: AW]   = 32'h0000_0200;
    @(negedge clk);
    n_tests++;
    if (s_write_fp !== 1'b1 || s_wdata_fp !== 32'h11 || grant_fp !== 2'd0) begin
      n_fail++;
      $display("FAIL lock_w1: wr=%b wd=%h g=%0d want 1 11 0", s_write_fp, s_wdata_fp, grant_fp);
    end
    @(negedge clk);
    n_tests++;
    if (m_ok_fp !== 4'b0001) begin
      n_fail++;
      $display("FAIL lock_ok1: ok=%b want 0001", m_ok_fp);
    end
    m_write[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (s_read_fp !== 1'b0 || s_write_fp !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_hold: rd=%b wr=%b g=%0d want 0 0", s_read_fp, s_write_fp, grant_fp);
    end
    m_write[0]       = 1'b1;
    m_wdata[0 +: DW] = 32'h22;
    @(negedge clk);
    n_tests++;
    if (s_write_fp !== 1'b1 || s_wdata_fp !== 32'h22 || grant_fp !== 2'd0) begin
      n_fail++;
      $display("FAIL lock_w2: wr=%b wd=%h g=%0d want 1 22 0", s_write_fp, s_wdata_fp, grant_fp);
    end
    @(negedge clk);
    n_tests++;
    if (m_ok_fp !== 4'b0001 || m_rdata_fp !== 32'h0) begin
      n_fail++;
      $display("FAIL lock_ok2: ok=%b rdata=%h want 0001 0", m_ok_fp, m_rdata_fp);
    end
    m_write[0] = 1'b0;
    m_lock[0]  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (s_read_fp !== 1'b1 || grant_fp !== 2'd1 || s_addr_fp !== 32'h0000_0200) begin
      n_fail++;
      $display("FAIL lock_m1: rd=%b g=%0d addr=%h want 1 1 00000200",
               s_read_fp, grant_fp, s_addr_fp);
    end
    @(negedge clk);
    n_tests++;
    if (m_ok_fp !== 4'b0010 || m_rdata_fp !== 32'hCAFE_0001) begin
      n_fail++;
      $display("FAIL lock_ok_m1: ok=%b rdata=%h want 0010 cafe0001", m_ok_fp, m_rdata_fp);
    end
    m_read  = '0;
    s_ok_fp = 1'b0;
  endtask

  task automatic test_reset_busy();
    logic [N-1:0] got;
    got = '0;
    do_reset();
    m_write[2]          = 1'b1;
    m_wdata[2*DW +: DW] = 32'h0000_A5A5;
    m_addr[2*AW +: AW]  = 32'h0000_0100;
    @(negedge clk);
    n_tests++;
    if (s_write_fp !== 1'b1 || s_addr_fp !== 32'h0000_0100) begin
      n_fail++;
      $display("FAIL rb_busy: wr=%b addr=%h want 1 00000100", s_write_fp, s_addr_fp);
    end
    #2 rstn = 1'b0;
    #1;
    n_tests++;
    if (s_write_fp !== 1'b0 || s_addr_fp !== '0 || s_wdata_fp !== '0 ||
        grant_fp !== 2'd0) begin
      n_fail++;
      $display("FAIL rb_async: wr=%b addr=%h wd=%h g=%0d want 0 0 0 0",
               s_write_fp, s_addr_fp, s_wdata_fp, grant_fp);
    end
    s_ok_fp = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (m_ok_fp !== '0) begin
        n_fail++;
        $display("FAIL rb_no_ok: ok=%b want 0000", m_ok_fp);
      end
    end
    m_write    = '0;
    m_read[1]  = 1'b1;
    s_rdata_fp = 32'h5555_AAAA;
    rstn       = 1'b1;
    @(negedge clk);
    n_tests++;
    if (s_read_fp !== 1'b0) begin
      n_fail++;
      $display("FAIL rb_sync_release: rd=%b want 0", s_read_fp);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (m_ok_fp !== '0) begin
        got = m_ok_fp;
        break;
      end
    end
    n_tests++;
    if (got !== 4'b0010 || m_rdata_fp !== 32'h5555_AAAA) begin
      n_fail++;
      $display("FAIL rb_after: ok=%b rdata=%h want 0010 5555aaaa", got, m_rdata_fp);
    end
    m_read  = '0;
    s_ok_fp = 1'b0;
  endtask

`ifdef MEM_ARBITER_STARVE_GUARD_EN
  task automatic test_starve();
    logic [N-1:0] who [8];
    int           np;
    np = 0;
    for (int k = 0; k < 8; k++) who[k] = '0;
    do_reset();
    s_ok_fp   = 1'b1;
    m_read[0] = 1'b1;
    m_read[3] = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (m_ok_fp !== '0) begin
        if (np < 8) who[np] = m_ok_fp;
        np++;
        if (m_ok_fp[3]) m_read[3] = 1'b0;
      end
    end
    n_tests++;
    if (np < 5 || who[0] !== 4'b0001 || who[1] !== 4'b0001 ||
        who[2] !== 4'b0001 || who[3] !== 4'b0001 || who[4] !== 4'b1000) begin
      n_fail++;
      $display("FAIL starve: pulses=%0d seq=%b %b %b %b %b want 0001x4 then 1000",
               np, who[0], who[1], who[2], who[3], who[4]);
    end
    m_read  = '0;
    s_ok_fp = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_fixed_priority();
    test_round_robin();
    test_lock();
    test_reset_busy();
`ifdef MEM_ARBITER_STARVE_GUARD_EN
    test_starve();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule
